// File: rtl/div_iter_param_pkg.sv
// Shared definitions for the iterative divider: state encodings and control constants.
package div_iter_param_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ZERO     = 3'd1,
        ST_PRESHIFT = 3'd2,
        ST_BUSY     = 3'd3,
        ST_FIX      = 3'd4,
        ST_DONE     = 3'd5
    } div_state_e;

    localparam logic RST_ENABLE    = 1'b1;
    localparam logic DIV_START     = 1'b1;
    localparam logic DIV_STOP      = 1'b0;
    localparam logic DIV_READY     = 1'b1;
    localparam logic DIV_NOT_READY = 1'b0;

endpackage

// File: rtl/div_lzc.sv
// Leading-zero counter; returns DATA_W for an all-zero input.
module div_lzc #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic [DATA_W-1:0] data,
    output logic [CNT_W-1:0]  zeros
);

    logic found;

    // Scan from the MSB; the first set bit fixes the count.
    always_comb begin
        zeros = CNT_W'(DATA_W);
        found = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (!found && data[i]) begin
                zeros = CNT_W'(DATA_W - 1 - i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_iter_param.sv
// Iterative restoring divider with optional leading-zero early-out.
// Result packed {remainder, quotient} for HI/LO writeback.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start_div_i with flush_i low
// ZERO     | divisor was zero; result forced to 0, flag raised
// PRESHIFT | skip leading zero chunks of |dividend| (EARLY_OUT only)
// BUSY     | BITS_PER_CYCLE restoring steps per clock, down-counter
// FIX      | apply signs to quotient and remainder
// DONE     | result valid; held while start_div_i stays high
module div_iter_param
    import div_iter_param_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int EARLY_OUT      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     operand_1_i,
    input  logic [DATA_W-1:0]     operand_2_i,
    input  logic                  start_div_i,
    input  logic                  signed_div_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  div_ready_o,
    output logic                  div_by_zero_o,
    output logic [2*DATA_W-1:0]   div_out
);

    localparam int ITER   = DATA_W / BITS_PER_CYCLE;
    localparam int CNT_W  = $clog2(ITER + 1);
    localparam int LZC_W  = $clog2(DATA_W) + 1;
    localparam int BPC_SH = $clog2(BITS_PER_CYCLE);

    div_state_e state, state_nxt;
    logic accept;

    logic [DATA_W-1:0]   dvd_q;
    logic [DATA_W-1:0]   dsr_q;
    logic [DATA_W-1:0]   rem_q;
    logic                sign1_q, sign2_q, sgn_q, dbz_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*DATA_W-1:0] out_q;

    logic [DATA_W-1:0]   abs1, abs2;
    logic [LZC_W-1:0]    lzc_raw, lzc_rnd;
    logic [DATA_W-1:0]   quo_fix, rem_fix;

    // Operand magnitudes; the divider works on unsigned values throughout.
    assign abs1 = (signed_div_i & operand_1_i[DATA_W-1]) ? -operand_1_i : operand_1_i;
    assign abs2 = (signed_div_i & operand_2_i[DATA_W-1]) ? -operand_2_i : operand_2_i;

    generate
        if (EARLY_OUT != 0) begin : g_lzc
            div_lzc #(.DATA_W(DATA_W), .CNT_W(LZC_W)) u_lzc (
                .data  (dvd_q),
                .zeros (lzc_raw)
            );
        end else begin : g_no_lzc
            assign lzc_raw = '0;
        end
    endgenerate

    // Only whole chunks are skipped so the iteration count stays integral.
    assign lzc_rnd = lzc_raw & ~LZC_W'(BITS_PER_CYCLE - 1);

    // Unrolled restoring steps: quotient bits enter the dividend register from the LSB.
    logic [DATA_W-1:0] rem_c [BITS_PER_CYCLE+1];
    logic [DATA_W-1:0] dvd_c [BITS_PER_CYCLE+1];

    assign rem_c[0] = rem_q;
    assign dvd_c[0] = dvd_q;

    generate
        for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
            logic [DATA_W:0]   shifted;
            logic [DATA_W-1:0] trial;
            logic              borrow;
            assign shifted      = {rem_c[k], dvd_c[k][DATA_W-1]};
            assign borrow       = shifted < {1'b0, dsr_q};
            // When no borrow occurs the true difference fits DATA_W bits.
            assign trial        = shifted[DATA_W-1:0] - dsr_q;
            assign rem_c[k+1]   = borrow ? shifted[DATA_W-1:0] : trial;
            assign dvd_c[k+1]   = {dvd_c[k][DATA_W-2:0], ~borrow};
        end
    endgenerate

    // Remainder takes the dividend's sign; quotient negative when signs differ.
    assign quo_fix = (sgn_q & (sign1_q ^ sign2_q)) ? -dvd_q : dvd_q;
    assign rem_fix = (sgn_q & sign1_q) ? -rem_q : rem_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) state <= ST_IDLE;
        else                   state <= state_nxt;
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        busy_o      = 1'b0;
        div_ready_o = DIV_NOT_READY;
        case (state)
            ST_IDLE: begin
                if (start_div_i == DIV_START && !flush_i) begin
                    accept = 1'b1;
                    if (operand_2_i == '0)  state_nxt = ST_ZERO;
                    else if (EARLY_OUT != 0) state_nxt = ST_PRESHIFT;
                    else                     state_nxt = ST_BUSY;
                end
            end
            ST_ZERO: begin
                busy_o    = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_PRESHIFT: begin
                busy_o    = 1'b1;
                state_nxt = (dvd_q == '0) ? ST_FIX : ST_BUSY;
            end
            ST_BUSY: begin
                busy_o = 1'b1;
                if (cnt_q == '0) state_nxt = ST_FIX;
            end
            ST_FIX: begin
                busy_o    = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                div_ready_o = DIV_READY;
                if (start_div_i == DIV_STOP) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (flush_i && state != ST_IDLE) state_nxt = ST_IDLE;
    end

    assign div_by_zero_o = div_ready_o & dbz_q;
    assign div_out       = out_q;

    // Datapath: operand latch, pre-shift, iteration, sign fix-up and result hold.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            sign1_q <= 1'b0;
            sign2_q <= 1'b0;
            sgn_q   <= 1'b0;
            dbz_q   <= 1'b0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else if (flush_i && state != ST_IDLE) begin
            dbz_q <= 1'b0;
            cnt_q <= '0;
            out_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        dvd_q   <= abs1;
                        dsr_q   <= abs2;
                        rem_q   <= '0;
                        sign1_q <= signed_div_i & operand_1_i[DATA_W-1];
                        sign2_q <= signed_div_i & operand_2_i[DATA_W-1];
                        sgn_q   <= signed_div_i;
                        dbz_q   <= (operand_2_i == '0);
                        cnt_q   <= CNT_W'(ITER - 1);
                        out_q   <= '0;
                    end
                end
                ST_ZERO: begin
                    out_q <= '0;
                end
                ST_PRESHIFT: begin
                    dvd_q <= dvd_q << lzc_rnd;
                    cnt_q <= CNT_W'(ITER - 1) - CNT_W'(lzc_rnd >> BPC_SH);
                end
                ST_BUSY: begin
                    dvd_q <= dvd_c[BITS_PER_CYCLE];
                    rem_q <= rem_c[BITS_PER_CYCLE];
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                end
                ST_FIX: begin
                    out_q <= {rem_fix, quo_fix};
                end
                ST_DONE: begin
                    if (start_div_i == DIV_STOP) begin
                        out_q <= '0;
                        dbz_q <= 1'b0;
                    end
                end
                default: begin
                    out_q <= '0;
                end
            endcase
        end
    end

endmodule
